ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//   Multi-register transfer sequencer (LDM/STM) beside the ControlUnit. The CU hands off a register list and base address.
//   The sequencer walks the list lowest register first, driving MAR/MDR/RF loads and the MOV/MOC memory handshake.
//   It then produces the base writeback value. Adds parametrised depth, four ARM addressing modes and a MOC timeout/abort.
// PARAMETERS
//   ADDR_W   32  address/base width; address arithmetic wraps modulo 2^ADDR_W
//   NREGS    16  register-list width; reg_sel width RS_W = $clog2(NREGS)
//   TIMEOUT  15  XFER cycles without MOC before abort (>=1)
// PORTS
//   clk       in   1       single clock, rising edge
//   clr       in   1       synchronous reset, active-high
//   start     in   1       request; accepted only in IDLE
//   is_load   in   1       1=LDM (memory->RF), 0=STM (RF->memory)
//   up        in   1       1=increment, 0=decrement
//   pre       in   1       1=pre-index (IB/DB), 0=post (IA/DA)
//   wback     in   1       1=issue base writeback
//   reg_list  in   NREGS   bit i set = transfer register i
//   base      in   ADDR_W  base address
//   MOC       in   1       memory operation complete
//   addr_out  out  ADDR_W  address presented with MAR_ld
//   reg_sel   out  RS_W    register being transferred
//   MAR_ld    out  1       load MAR from addr_out
//   MDR_ld    out  1       load MDR (from RF on store, from memory on load)
//   MOV       out  1       memory operation valid
//   R_W       out  1       1=read, 0=write; meaningful only while MOV=1
//   RF_ld     out  1       write MDR into RF[reg_sel]
//   wb_ld     out  1       write wb_addr into base register
//   wb_addr   out  ADDR_W  writeback value
//   busy      out  1       1 in every state except IDLE
//   done      out  1       one-cycle completion pulse
//   abort     out  1       one-cycle timeout pulse
//   count     out  $clog2(NREGS+1)  transfers completed
// BEHAVIOUR
//   Reset: clr sampled high -> state IDLE, pending=0, timer=0, count=0; every output 0 the next cycle.
//     clr mid-operation discards the transfer silently: no done, no abort, no wb_ld.
//   Accept: start=1 in IDLE latches all inputs. pending<=reg_list, count<=0, N=popcount(reg_list).
//     Next state ADDR, or WB if N=0. start while busy is ignored.
//   Start address:
//     IA = base, IB = base+4, DA = base-4N+4, DB = base-4N.
//     Addresses always ascend by 4, with the lowest register at the lowest address.
//   Writeback value: wb_addr = base+4N (up=1) or base-4N (up=0), held from accept until the next accept.
//   States (Moore outputs, one cycle each unless stated):
//     IDLE  - all strobes 0; on accepted start -> ADDR or WB as above.
//     ADDR  - MAR_ld=1, addr_out=cur_addr, reg_sel=lowest set bit of pending; STM also MDR_ld=1; timer<=0 -> XFER.
//     XFER  - MOV=1, R_W=is_load; timer++ each cycle; stays until MOC=1.
//             On MOC=1 with LDM: MDR_ld=1 this cycle -> WRITE.
//             On MOC=1 with STM: clear pending bit, count++ -> NEXT.
//             If timer reaches TIMEOUT with MOC=0 -> ABORT.
//             MOC=1 on the TIMEOUT cycle counts as success, not abort.
//     WRITE - RF_ld=1, reg_sel held; clear pending bit, count++ -> NEXT.
//     NEXT  - combinational decision, no cycle: pending=0 -> WB; else cur_addr+=4 -> ADDR.
//     WB    - wb_ld=wback -> DONE.
//     DONE  - done=1 -> IDLE.
//     ABORT - abort=1, MOV=0, no writeback -> IDLE; count keeps completed transfers.
//   MOC outside XFER is ignored. addr_out and reg_sel hold their last value outside ADDR/XFER/WRITE.
//   Latency with zero wait (MOC=1 in first XFER cycle): LDM 3N+2 cycles, STM 2N+2 cycles, from accept edge to DONE inclusive.
// TESTING
//   clr=1 for 2 clks, then 0 -> all outputs 0, busy=0; start pulsed during clr -> ignored.
//   LDM IA base=0x100, list=0x000B, wback=1, MOC=1 -> addr 0x100/0x104/0x108, reg_sel 0/1/3.
//     Expect 3 RF_ld pulses, wb_addr=0x10C, done in cycle 11, count=3.
//   STM DB base=0x200, list=0x8001 -> addr 0x1F8 (r0) then 0x1FC (r15), R_W=0, no RF_ld.
//     Expect wb_addr=0x1F8, done in cycle 6.
//   IA base=0xFFFFFFFC, list=0x0003 -> addr 0xFFFFFFFC then 0x00000000, wb_addr=0x00000004 (wrap).
//   MOC held 0, TIMEOUT=15 -> MOV high 15 cycles, then abort=1 for 1 cycle; no wb_ld, no done, count=0.
//   list=0, wback=1 -> no MAR_ld/MOV; wb_ld=1 with wb_addr=base, then done; start while busy ignored.
//   clr asserted during a XFER cycle -> IDLE next cycle, MOV=0, no done/abort.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer sequencer: walks a register list lowest-first,
// drives MAR/MDR/RF strobes and the MOV/MOC handshake, then issues base writeback.
module ldm_stm_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned RS_W   = $clog2(NREGS),
    localparam int unsigned CNT_W  = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    input  logic [NREGS-1:0]  reg_list,
    input  logic [ADDR_W-1:0] base,
    input  logic              MOC,
    output logic [ADDR_W-1:0] addr_out,
    output logic [RS_W-1:0]   reg_sel,
    output logic              MAR_ld,
    output logic              MDR_ld,
    output logic              MOV,
    output logic              R_W,
    output logic              RF_ld,
    output logic              wb_ld,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned TM_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_XFER, S_WRITE, S_WB, S_DONE, S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [NREGS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]   count_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [TM_W-1:0]    timer_q;
    logic               is_load_q, wback_q, mdr_ld_q;
    logic               ld_d, wback_d, retire;
    logic [CNT_W-1:0]   n_regs;
    logic [ADDR_W-1:0]  four_n, start_addr, wb_value;

    function automatic logic [RS_W-1:0] lowest(input logic [NREGS-1:0] v);
        logic found;
        lowest = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (v[i] && !found) begin
                lowest = RS_W'(i);
                found  = 1'b1;
            end
        end
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
        popcount = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            popcount = popcount + CNT_W'(v[i]);
    endfunction

    // Every mode lays registers out ascending; only the block's start differs.
    always_comb begin
        n_regs   = popcount(reg_list);
        four_n   = ADDR_W'(n_regs) << 2;
        wb_value = up ? (base + four_n) : (base - four_n);
        case ({up, pre})
            2'b10:   start_addr = base;
            2'b11:   start_addr = base + ADDR_W'(4);
            2'b00:   start_addr = base - four_n + ADDR_W'(4);
            default: start_addr = base - four_n;
        endcase
    end

    assign ld_d    = (state_q == S_IDLE) ? is_load : is_load_q;
    assign wback_d = (state_q == S_IDLE) ? wback   : wback_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        count_d    = count;
        cur_addr_d = cur_addr_q;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d  = reg_list;
                    count_d    = '0;
                    cur_addr_d = start_addr;
                    state_d    = (reg_list == '0) ? S_WB : S_ADDR;
                end
            end
            S_ADDR:  state_d = S_XFER;
            S_XFER: begin
                if (MOC) begin
                    if (is_load_q) state_d = S_WRITE;
                    else           retire  = 1'b1;
                end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_WRITE: retire  = 1'b1;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The NEXT decision folds into the retiring cycle so it costs no clock.
        if (retire) begin
            pending_d = pending_q & ~(NREGS'(1) << reg_sel);
            count_d   = count + 1'b1;
            if (pending_d == '0) begin
                state_d = S_WB;
            end else begin
                cur_addr_d = cur_addr_q + ADDR_W'(4);
                state_d    = S_ADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            count      <= '0;
            cur_addr_q <= '0;
            timer_q    <= '0;
            is_load_q  <= 1'b0;
            wback_q    <= 1'b0;
            wb_addr    <= '0;
            addr_out   <= '0;
            reg_sel    <= '0;
            MAR_ld     <= 1'b0;
            mdr_ld_q   <= 1'b0;
            MOV        <= 1'b0;
            R_W        <= 1'b0;
            RF_ld      <= 1'b0;
            wb_ld      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            count      <= count_d;
            cur_addr_q <= cur_addr_d;
            if (state_q == S_IDLE && start) begin
                is_load_q <= is_load;
                wback_q   <= wback;
                wb_addr   <= wb_value;
            end
            if (state_d == S_ADDR)
                timer_q <= '0;
            else if (state_q == S_XFER)
                timer_q <= timer_q + 1'b1;
            if (state_d == S_ADDR) begin
                addr_out <= cur_addr_d;
                reg_sel  <= lowest(pending_d);
            end
            // Strobes are decoded from the state being entered, so they are Moore and registered.
            MAR_ld   <= (state_d == S_ADDR);
            mdr_ld_q <= (state_d == S_ADDR) && !ld_d;
            MOV      <= (state_d == S_XFER);
            R_W      <= (state_d == S_XFER) && ld_d;
            RF_ld    <= (state_d == S_WRITE);
            wb_ld    <= (state_d == S_WB) && wback_d;
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            abort    <= (state_d == S_ABORT);
        end
    end

    // A load captures memory data in the very cycle MOC arrives.
    assign MDR_ld = mdr_ld_q | ((state_q == S_XFER) && is_load_q && MOC);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed vector table, hand-written corner sequences,
// and randomized transfers checked against a list/arithmetic reference model.
module tb_ldm_stm_sequencer;

    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        clr, start, is_load, up, pre, wback, MOC;
    logic [15:0] reg_list;
    logic [31:0] base;
    logic [31:0] addr_out, wb_addr;
    logic [3:0]  reg_sel;
    logic        MAR_ld, MDR_ld, MOV, R_W, RF_ld, wb_ld, busy, done, abort;
    logic [4:0]  count;

    ldm_stm_sequencer #(.ADDR_W(32), .NREGS(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .start(start), .is_load(is_load), .up(up), .pre(pre),
        .wback(wback), .reg_list(reg_list), .base(base), .MOC(MOC),
        .addr_out(addr_out), .reg_sel(reg_sel), .MAR_ld(MAR_ld), .MDR_ld(MDR_ld),
        .MOV(MOV), .R_W(R_W), .RF_ld(RF_ld), .wb_ld(wb_ld), .wb_addr(wb_addr),
        .busy(busy), .done(done), .abort(abort), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int unsigned wait_tab[16];
    logic [31:0] obs_addr[$];
    int unsigned obs_sel[$];
    int unsigned obs_rf[$];
    int          done_cyc, abort_cyc, wb_cnt, mov_cnt;
    logic [31:0] wb_val;
    int unsigned end_count;

    typedef struct {
        logic        ld, u, p, wb;
        logic [15:0] list;
        logic [31:0] b;
        int unsigned wt;
        logic [31:0] first_addr;
        logic [31:0] wb_exp;
        int          done_at;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_and_check(input logic ld, input logic u, input logic p, input logic wb,
                                 input logic [15:0] list, input logic [31:0] b);
        int          cyc;
        int unsigned idx, wctr, n, stop_k, lat, mov_exp, exp_naddr, exp_rf;
        bit          fin;
        int unsigned regs[$];
        logic [31:0] first, wbv, four_n;

        obs_addr.delete(); obs_sel.delete(); obs_rf.delete();
        done_cyc = -1; abort_cyc = -1; wb_cnt = 0; mov_cnt = 0; wb_val = '0; end_count = 0;

        @(negedge clk);
        is_load = ld; up = u; pre = p; wback = wb; reg_list = list; base = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // scramble the request inputs: the sequencer must have latched them
        is_load = ~ld; up = ~u; pre = ~p; wback = ~wb;
        reg_list = 16'($urandom); base = $urandom;
        cyc = 1; idx = 0; wctr = 0; fin = 0;
        while (!fin && cyc < 600) begin
            if (MAR_ld) begin
                obs_addr.push_back(addr_out);
                obs_sel.push_back(32'(reg_sel));
                chk("mdr_ld_at_addr", 32'(MDR_ld), 32'(!ld));
                wctr = 0;
            end
            if (MOV) begin
                mov_cnt++;
                chk("r_w", 32'(R_W), 32'(ld));
                if (idx < 16 && wctr == wait_tab[idx]) begin
                    MOC = 1'b1;
                    idx++;
                    if (ld) begin
                        #1;
                        chk("mdr_ld_on_moc", 32'(MDR_ld), 32'd1);
                    end
                end else begin
                    MOC = 1'b0;
                end
                wctr++;
            end else begin
                MOC = 1'b0;
            end
            if (RF_ld) obs_rf.push_back(32'(reg_sel));
            if (wb_ld) begin wb_cnt++; wb_val = wb_addr; end
            if (done)  begin done_cyc = cyc;  end_count = 32'(count); fin = 1; end
            if (abort) begin abort_cyc = cyc; end_count = 32'(count); fin = 1; end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        MOC = 1'b0;
        chk("op_terminates", 32'(fin), 32'd1);
        @(negedge clk);
        chk("idle_after_end", 32'(busy), 32'd0);
        chk("end_pulse_width", 32'(done | abort), 32'd0);

        // reference model: register order, addresses and timing from the transfer rules
        n = 0;
        for (int i = 0; i < 16; i++) if (list[i]) begin regs.push_back(i); n++; end
        four_n = 4 * n;
        if (u) first = p ? b + 4 : b;
        else   first = p ? b - four_n : b - four_n + 4;
        wbv = u ? b + four_n : b - four_n;
        stop_k = n;
        for (int unsigned k = 0; k < n; k++)
            if (stop_k == n && wait_tab[k] >= TMO) stop_k = k;
        lat = 0; mov_exp = 0;
        for (int unsigned k = 0; k < stop_k; k++) begin
            lat     += 1 + (wait_tab[k] + 1) + (ld ? 1 : 0);
            mov_exp += wait_tab[k] + 1;
        end
        if (stop_k == n) begin
            chk("done_cycle", done_cyc, lat + 2);
            chk("abort_cycle", abort_cyc, -1);
            chk("wb_ld_pulses", wb_cnt, wb ? 1 : 0);
            if (wb_cnt > 0) chk("wb_ld_value", wb_val, wbv);
            exp_naddr = n;
            exp_rf    = ld ? n : 0;
        end else begin
            mov_exp += TMO;
            chk("abort_cycle", abort_cyc, lat + 1 + TMO + 1);
            chk("done_cycle", done_cyc, -1);
            chk("wb_ld_pulses", wb_cnt, 0);
            exp_naddr = stop_k + 1;
            exp_rf    = ld ? stop_k : 0;
        end
        chk("count", end_count, stop_k);
        chk("mov_cycles", mov_cnt, mov_exp);
        chk("wb_addr_held", wb_addr, wbv);
        chk("num_addr", obs_addr.size(), exp_naddr);
        for (int unsigned k = 0; k < exp_naddr && k < obs_addr.size(); k++) begin
            chk("addr", obs_addr[k], first + 4 * k);
            chk("reg_sel", obs_sel[k], regs[k]);
        end
        chk("num_rf_ld", obs_rf.size(), exp_rf);
        for (int unsigned k = 0; k < exp_rf && k < obs_rf.size(); k++)
            chk("rf_reg_sel", obs_rf[k], regs[k]);
    endtask

    vec_t vecs[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h000B, 32'h0000_0100,  0, 32'h0000_0100, 32'h0000_010C, 11};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 32'h0000_0200,  0, 32'h0000_01F8, 32'h0000_01F8,  6};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 32'h0000_0004,  6};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 32'h0000_1000,  0, 32'h0000_1004, 32'h0000_1004,  5};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h00F0, 32'h0000_1000,  0, 32'h0000_0FF4, 32'h0000_0FF0, 10};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 32'h0000_0040, 14, 32'h0000_0040, 32'h0000_003C, 19};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h0000_0300,  0, 32'h0000_0000, 32'h0000_0300,  2};

        // reset, with start asserted throughout
        clr = 1'b1; start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1;
        reg_list = 16'hFFFF; base = 32'h1234_5678; MOC = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({MAR_ld, MDR_ld, MOV, R_W, RF_ld, wb_ld, done, abort}), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_addr_out", addr_out, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_reg_sel", 32'(reg_sel), 0);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_during_clr_ignored", 32'(busy), 0);

        foreach (vecs[v]) begin
            foreach (wait_tab[k]) wait_tab[k] = vecs[v].wt;
            run_and_check(vecs[v].ld, vecs[v].u, vecs[v].p, vecs[v].wb, vecs[v].list, vecs[v].b);
            if (obs_addr.size() > 0) chk("vec_first_addr", obs_addr[0], vecs[v].first_addr);
            chk("vec_wb_addr", wb_addr, vecs[v].wb_exp);
            chk("vec_done_cycle", done_cyc, vecs[v].done_at);
        end

        // MOC never arrives: 15 MOV cycles then a single abort
        foreach (wait_tab[k]) wait_tab[k] = 99;
        run_and_check(1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 32'h0000_0800);
        chk("tmo_mov_cycles", mov_cnt, 15);
        chk("tmo_abort_cycle", abort_cyc, 17);
        chk("tmo_no_done", done_cyc, -1);
        chk("tmo_no_wb", wb_cnt, 0);
        chk("tmo_count", end_count, 0);

        // abort after one completed transfer keeps the count
        foreach (wait_tab[k]) wait_tab[k] = 0;
        wait_tab[1] = 99;
        run_and_check(1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 32'h0000_0900);
        chk("mid_abort_count", end_count, 1);

        // start while busy is ignored (empty list: WB then DONE)
        @(negedge clk);
        is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1; reg_list = 16'h0000;
        base = 32'h0000_0300; start = 1'b1;
        @(negedge clk);
        reg_list = 16'hFFFF; base = 32'h0;
        chk("busy_wb_ld", 32'(wb_ld), 1);
        chk("busy_wb_addr", wb_addr, 32'h0000_0300);
        chk("busy_no_mar", 32'(MAR_ld | MOV), 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_done", 32'(done), 1);
        chk("busy_wb_addr_kept", wb_addr, 32'h0000_0300);
        @(negedge clk);
        chk("busy_back_idle", 32'(busy | MAR_ld), 0);

        // clr during XFER drops the transfer silently
        @(negedge clk);
        is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1; reg_list = 16'h0003;
        base = 32'h0000_0500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_seq_mar", 32'(MAR_ld), 1);
        @(negedge clk);
        chk("clr_seq_mov", 32'(MOV), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_mov", 32'(MOV), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_pulses", 32'({done, abort, wb_ld}), 0);
        chk("clr_count", 32'(count), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || abort || busy || wb_ld) seen = 1;
        end
        chk("clr_no_late_activity", 32'(seen), 0);

        // randomized transfers against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [15:0] lst;
            foreach (wait_tab[k])
                wait_tab[k] = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 2)
                                                          : $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       lst = 16'h0000;
                1:       lst = 16'h0001 << $urandom_range(0, 15);
                default: lst = 16'($urandom);
            endcase
            run_and_check(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), lst, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
